// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the load/store controller: size codes, fault causes, FSM states,
// bus request and register write-enable levels, plus the alignment rule.
package lsu_ctrl_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_BUSERR   = 2'd2,
        CAUSE_TIMEOUT  = 2'd3
    } cause_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    localparam logic RIB_REQ      = 1'b1;
    localparam logic RIB_NREQ     = 1'b0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    // The byte offset must be a multiple of the access size in bytes.
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] alow);
        case (size)
            SZ_H:    return alow[0];
            SZ_W:    return |alow[1:0];
            SZ_D:    return |alow;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// Lane steering shared by both directions: byte enables, replicated store data and
// sign/zero-extended load data. Purely combinational, no backpressure.
module lsu_align
    import lsu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int NB    = DATA_W / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [OFF_W-1:0]  offset_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [NB-1:0]     be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] ldata_o
);

    logic [NB-1:0]     lane_m;
    logic [DATA_W-1:0] data_m;
    logic [DATA_W-1:0] shifted;
    logic              sgn;

    assign shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        lane_m  = '1;
        data_m  = '1;
        sgn     = shifted[DATA_W-1];
        wdata_o = wdata_i;
        case (size_i)
            SZ_B: begin
                lane_m  = NB'(1);
                data_m  = DATA_W'(64'hFF);
                sgn     = shifted[7];
                wdata_o = {NB{wdata_i[7:0]}};
            end
            SZ_H: begin
                lane_m  = NB'(3);
                data_m  = DATA_W'(64'hFFFF);
                sgn     = shifted[15];
                wdata_o = {(NB/2){wdata_i[15:0]}};
            end
            SZ_W: begin
                lane_m  = NB'(15);
                data_m  = DATA_W'(64'hFFFF_FFFF);
                sgn     = shifted[31];
                wdata_o = {(NB/4){wdata_i[31:0]}};
            end
            default: ;
        endcase
    end

    assign be_o    = lane_m << offset_i;
    assign ldata_o = (shifted & data_m) | ((sgn && !unsigned_i) ? ~data_m : '0);

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store FSM on the RIB bus; best case accept->wb_valid is 3 cycles
// (1 for a misaligned access). req_ready_o only in IDLE, stall_o holds the pipeline otherwise.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    localparam int NB     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [NB-1:0]     mem_be_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_err_i,
    output logic              wb_valid_o,
    output logic              wb_we_o,
    output logic [4:0]        wb_waddr_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic              stall_o,
    output logic              exc_o,
    output logic [1:0]        exc_cause_o
);

    localparam int OFF_W    = $clog2(NB);
    localparam int CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    state_e            state_q;
    logic              mem_req_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q, uns_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [4:0]        rd_q;
    logic              wb_valid_q, wb_we_q, exc_q;
    logic [4:0]        wb_waddr_q;
    logic [DATA_W-1:0] wb_wdata_q;
    cause_e            exc_cause_q;

    logic              bad_acc, tmo_hit, fin_d, wb_we_d;
    cause_e            cause_d;
    logic [4:0]        waddr_d;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] ld_data;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .offset_i   (addr_q[OFF_W-1:0]),
        .rdata_i    (mem_rdata_i),
        .wdata_i    (wdata_q),
        .be_o       (be),
        .wdata_o    (mem_wdata_o),
        .ldata_o    (ld_data)
    );

    assign bad_acc = misaligned(req_size_i, req_addr_i[2:0]) || (DATA_W == 32 && req_size_i == SZ_D);
    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TMO_LAST));

    // Decide in the current cycle whether the access completes, and why.
    always_comb begin
        fin_d   = 1'b0;
        cause_d = CAUSE_NONE;
        case (state_q)
            S_IDLE: if (req_valid_i && bad_acc) begin
                fin_d   = 1'b1;
                cause_d = CAUSE_MISALIGN;
            end
            S_REQ: if (!mem_gnt_i && tmo_hit) begin
                fin_d   = 1'b1;
                cause_d = CAUSE_TIMEOUT;
            end
            S_WAIT: if (mem_rvalid_i) begin
                fin_d   = 1'b1;
                cause_d = mem_err_i ? CAUSE_BUSERR : CAUSE_NONE;
            end else if (tmo_hit) begin
                fin_d   = 1'b1;
                cause_d = CAUSE_TIMEOUT;
            end
            default: ;
        endcase
    end

    assign wb_we_d = fin_d && (cause_d == CAUSE_NONE) && (we_q == WriteDisable) && (rd_q != 5'd0);
    assign waddr_d = (state_q == S_IDLE) ? req_rd_i : rd_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            mem_req_q   <= RIB_NREQ;
            cnt_q       <= '0;
            we_q        <= WriteDisable;
            uns_q       <= 1'b0;
            size_q      <= SZ_B;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_waddr_q  <= '0;
            wb_wdata_q  <= '0;
            exc_q       <= 1'b0;
            exc_cause_q <= CAUSE_NONE;
        end else begin
            wb_valid_q  <= fin_d;
            wb_we_q     <= wb_we_d;
            wb_waddr_q  <= fin_d ? waddr_d : '0;
            wb_wdata_q  <= wb_we_d ? ld_data : '0;
            exc_q       <= fin_d && (cause_d != CAUSE_NONE);
            exc_cause_q <= cause_d;
            case (state_q)
                S_IDLE: if (req_valid_i) begin
                    we_q    <= req_we_i;
                    uns_q   <= req_unsigned_i;
                    size_q  <= req_size_i;
                    addr_q  <= req_addr_i;
                    wdata_q <= req_wdata_i;
                    rd_q    <= req_rd_i;
                    cnt_q   <= '0;
                    if (bad_acc) begin
                        state_q <= S_RESP;
                    end else begin
                        state_q   <= S_REQ;
                        mem_req_q <= RIB_REQ;
                    end
                end
                S_REQ: if (mem_gnt_i) begin
                    state_q   <= S_WAIT;
                    mem_req_q <= RIB_NREQ;
                    cnt_q     <= '0;
                end else if (fin_d) begin
                    state_q   <= S_RESP;
                    mem_req_q <= RIB_NREQ;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_WAIT: if (fin_d) begin
                    state_q <= S_RESP;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_RESP: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign stall_o     = (state_q == S_REQ) || (state_q == S_WAIT) || (req_valid_i && state_q != S_IDLE);
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_req_q && we_q;
    assign mem_addr_o  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_be_o    = mem_req_q ? be : '0;
    assign wb_valid_o  = wb_valid_q;
    assign wb_we_o     = wb_we_q;
    assign wb_waddr_o  = wb_waddr_q;
    assign wb_wdata_o  = wb_wdata_q;
    assign exc_o       = exc_q;
    assign exc_cause_o = exc_cause_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: a 32-bit and a 64-bit instance (both TIMEOUT=4) on shared stimulus,
// a hand-computed vector table, reset corner sequences and randomized accesses vs a model.
module tb_lsu_ctrl;

    localparam int TMO = 4;

    typedef struct packed {
        logic        sel;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [4:0]  rd;
        logic [63:0] rdata;
        logic        err;
        int          gd;
        int          rdly;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
        logic [63:0] wb;
        logic        wbwe;
        logic [1:0]  cause;
    } exp_t;

    typedef struct packed {
        vec_t v;
        exp_t e;
    } tv_t;

    typedef struct packed {
        logic        req_ready, mem_req, mem_we;
        logic [31:0] mem_addr;
        logic [7:0]  mem_be;
        logic [63:0] mem_wdata;
        logic        wb_valid, wb_we;
        logic [4:0]  wb_waddr;
        logic [63:0] wb_wdata;
        logic        stall, exc;
        logic [1:0]  cause;
    } obs_t;

    logic clk = 1'b0;
    logic rst, sel;
    logic req_valid, req_we, req_uns, gnt, rvalid, err;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, rdata;
    logic [4:0]  req_rd;
    int checks = 0;
    int failures = 0;
    int txn = 0;

    logic        a_rdy, a_req, a_we, a_wbv, a_wbwe, a_stall, a_exc;
    logic [31:0] a_addr, a_wdat, a_wbd;
    logic [3:0]  a_be;
    logic [4:0]  a_wba;
    logic [1:0]  a_cause;
    logic        b_rdy, b_req, b_we, b_wbv, b_wbwe, b_stall, b_exc;
    logic [31:0] b_addr;
    logic [63:0] b_wdat, b_wbd;
    logic [7:0]  b_be;
    logic [4:0]  b_wba;
    logic [1:0]  b_cause;
    obs_t ob;

    always #5 clk = ~clk;

    lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TMO)) dut32 (
        .clk(clk), .rst(rst), .req_valid_i(req_valid && !sel), .req_ready_o(a_rdy),
        .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata[31:0]), .req_rd_i(req_rd), .mem_req_o(a_req), .mem_we_o(a_we),
        .mem_addr_o(a_addr), .mem_be_o(a_be), .mem_wdata_o(a_wdat), .mem_gnt_i(gnt),
        .mem_rvalid_i(rvalid), .mem_rdata_i(rdata[31:0]), .mem_err_i(err), .wb_valid_o(a_wbv),
        .wb_we_o(a_wbwe), .wb_waddr_o(a_wba), .wb_wdata_o(a_wbd), .stall_o(a_stall),
        .exc_o(a_exc), .exc_cause_o(a_cause));

    lsu_ctrl #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TMO)) dut64 (
        .clk(clk), .rst(rst), .req_valid_i(req_valid && sel), .req_ready_o(b_rdy),
        .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_rd_i(req_rd), .mem_req_o(b_req), .mem_we_o(b_we),
        .mem_addr_o(b_addr), .mem_be_o(b_be), .mem_wdata_o(b_wdat), .mem_gnt_i(gnt),
        .mem_rvalid_i(rvalid), .mem_rdata_i(rdata), .mem_err_i(err), .wb_valid_o(b_wbv),
        .wb_we_o(b_wbwe), .wb_waddr_o(b_wba), .wb_wdata_o(b_wbd), .stall_o(b_stall),
        .exc_o(b_exc), .exc_cause_o(b_cause));

    always_comb begin
        if (sel) ob = '{b_rdy, b_req, b_we, b_addr, b_be, b_wdat, b_wbv, b_wbwe, b_wba, b_wbd,
                        b_stall, b_exc, b_cause};
        else     ob = '{a_rdy, a_req, a_we, a_addr, {4'h0, a_be}, {32'h0, a_wdat}, a_wbv, a_wbwe,
                        a_wba, {32'h0, a_wbd}, a_stall, a_exc, a_cause};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (txn %0d dw%0d): got %h want %h", name, txn, sel ? 64 : 32, act, exp);
        end
    endtask

    function automatic tv_t tv(input logic s, we, input logic [1:0] sz, input logic u,
                               input logic [31:0] a, input logic [63:0] wd, input logic [4:0] rd,
                               input logic [63:0] rdat, input logic e, input int gd, rdly,
                               input logic [31:0] ea, input logic [7:0] ebe,
                               input logic [63:0] ewd, ewb, input logic ewe, input logic [1:0] ec);
        tv_t t;
        t.v = '{s, we, sz, u, a, wd, rd, rdat, e, gd, rdly};
        t.e = '{ea, ebe, ewd, ewb, ewe, ec};
        return t;
    endfunction

    // Reference: lanes and extension worked out byte by byte from the access rules.
    function automatic exp_t model(input vec_t v);
        exp_t e;
        int nb, by, off;
        logic [63:0] rd, m, lane;
        nb = v.sel ? 8 : 4;
        by = 1 << v.size;
        off = int'(v.addr[2:0]) % nb;
        e = '0;
        e.addr = v.addr - 32'(off);
        for (int i = 0; i < by && off + i < nb; i++) e.be[off+i] = 1'b1;
        for (int i = 0; i < nb; i++) e.wdata[8*i +: 8] = v.wdata[8*(i % by) +: 8];
        rd = (nb == 4) ? {32'h0, v.rdata[31:0]} : v.rdata;
        m = (by == 8) ? '1 : (64'd1 << (8 * by)) - 64'd1;
        lane = (rd >> (8 * off)) & m;
        if (!v.uns && lane[8*by-1]) lane = lane | ~m;
        if (nb == 4) lane = lane & 64'hFFFF_FFFF;
        e.wb = lane;
        if (by > nb || off % by != 0) e.cause = 2'd1;
        else if (v.gd >= TMO || v.rdly >= TMO) e.cause = 2'd3;
        else if (v.err) e.cause = 2'd2;
        else e.cause = 2'd0;
        e.wbwe = (e.cause == 2'd0) && !v.we && (v.rd != 5'd0);
        return e;
    endfunction

    task automatic issue(input vec_t v);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_uns = v.uns;
        req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
    endtask

    task automatic run(input tv_t t);
        logic granted;
        txn++;
        granted = 1'b0;
        sel = t.v.sel;
        #1;
        chk("idle_ready", ob.req_ready, 1);
        issue(t.v);
        @(negedge clk);
        req_valid = 1'b0;
        if (t.e.cause != 2'd1) begin
            for (int c = 0; c < TMO; c++) begin
                chk("req_hold", ob.mem_req, 1);
                chk("req_addr", ob.mem_addr, t.e.addr);
                chk("req_be", ob.mem_be, t.e.be);
                chk("req_we", ob.mem_we, t.v.we);
                if (t.v.we) chk("req_wdata", ob.mem_wdata, t.e.wdata);
                chk("req_stall", ob.stall, 1);
                chk("req_notready", ob.req_ready, 0);
                if (c == t.v.gd) begin
                    gnt = 1'b1;
                    @(negedge clk);
                    gnt = 1'b0;
                    granted = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (granted) begin
                for (int w = 0; w < TMO; w++) begin
                    chk("wait_noreq", ob.mem_req, 0);
                    chk("wait_stall", ob.stall, 1);
                    chk("wait_nowb", ob.wb_valid, 0);
                    if (w == t.v.rdly) begin
                        rvalid = 1'b1; rdata = t.v.rdata; err = t.v.err;
                        @(negedge clk);
                        rvalid = 1'b0; err = 1'b0; rdata = '0;
                        break;
                    end
                    @(negedge clk);
                end
            end
        end
        chk("wb_valid", ob.wb_valid, 1);
        chk("exc", ob.exc, t.e.cause != 2'd0);
        chk("cause", ob.cause, t.e.cause);
        chk("wb_we", ob.wb_we, t.e.wbwe);
        chk("resp_noreq", ob.mem_req, 0);
        if (t.e.wbwe) begin
            chk("wb_waddr", ob.wb_waddr, t.v.rd);
            chk("wb_wdata", ob.wb_wdata, t.e.wb);
        end
        @(negedge clk);
        chk("wb_pulse", ob.wb_valid, 0);
        chk("back_idle", ob.req_ready, 1);
    endtask

    task automatic chk_reset_state();
        chk("rst_ready", ob.req_ready, 1);
        chk("rst_req", ob.mem_req, 0);
        chk("rst_be", ob.mem_be, 0);
        chk("rst_addr", ob.mem_addr, 0);
        chk("rst_wbv", ob.wb_valid, 0);
        chk("rst_exc", ob.exc, 0);
        chk("rst_stall", ob.stall, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        tv_t tbl[$];
        tv_t t;
        vec_t v;
        rst = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_uns = 1'b0;
        req_addr = '0; req_wdata = '0; req_rd = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; err = 1'b0;
        repeat (2) @(negedge clk);
        sel = 1'b0; #1; chk_reset_state();
        sel = 1'b1; #1; chk_reset_state();
        rst = 1'b1;
        @(negedge clk);

        //    sel we sz u addr        wdata        rd rdata                  e gd rd  ea         be     ewd                   ewb                    we c
        tbl.push_back(tv(0, 0, 0, 0, 32'h103, 64'h0,       5, 64'h80FF_1234,         0, 0, 0, 32'h100, 8'h08, 64'h0, 64'hFFFF_FF80, 1, 0));
        tbl.push_back(tv(0, 1, 1, 0, 32'h202, 64'hBEEF,    0, 64'h0,                 0, 1, 2, 32'h200, 8'h0C, 64'hBEEF_BEEF, 64'h0, 0, 0));
        tbl.push_back(tv(0, 0, 2, 0, 32'h102, 64'h0,       4, 64'h0,                 0, 0, 0, 32'h100, 8'h00, 64'h0, 64'h0, 0, 1));
        tbl.push_back(tv(0, 0, 2, 0, 32'h200, 64'h0,       7, 64'h1234_5678,         0, 3, 0, 32'h200, 8'h0F, 64'h0, 64'h1234_5678, 1, 0));
        tbl.push_back(tv(0, 0, 2, 0, 32'h300, 64'h0,       3, 64'hDEAD_BEEF,         1, 0, 1, 32'h300, 8'h0F, 64'h0, 64'h0, 0, 2));
        tbl.push_back(tv(0, 0, 2, 0, 32'h400, 64'h0,       2, 64'h0,                 0, 0, 9, 32'h400, 8'h0F, 64'h0, 64'h0, 0, 3));
        tbl.push_back(tv(1, 0, 3, 0, 32'h108, 64'h0,       9, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 32'h108, 8'hFF, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 0));
        tbl.push_back(tv(0, 0, 3, 0, 32'h108, 64'h0,       9, 64'h0,                 0, 0, 0, 32'h108, 8'h00, 64'h0, 64'h0, 0, 1));
        tbl.push_back(tv(1, 0, 0, 1, 32'h10D, 64'h0,      10, 64'hAABB_CCDD_EEFF_1122, 0, 2, 1, 32'h108, 8'h20, 64'h0, 64'hCC, 1, 0));
        tbl.push_back(tv(1, 0, 1, 0, 32'h106, 64'h0,      11, 64'h8001_2233_4455_6677, 0, 0, 3, 32'h100, 8'hC0, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 1, 0));
        tbl.push_back(tv(1, 1, 2, 0, 32'h104, 64'hCAFE_F00D, 0, 64'h0,               0, 0, 0, 32'h100, 8'hF0, 64'hCAFE_F00D_CAFE_F00D, 64'h0, 0, 0));
        tbl.push_back(tv(0, 1, 0, 0, 32'h001, 64'h5A,      6, 64'h0,                 0, 9, 0, 32'h000, 8'h02, 64'h5A5A_5A5A, 64'h0, 0, 3));
        tbl.push_back(tv(0, 0, 0, 0, 32'h000, 64'h0,       0, 64'h7F,                0, 0, 0, 32'h000, 8'h01, 64'h0, 64'h0, 0, 0));
        tbl.push_back(tv(1, 0, 2, 0, 32'h104, 64'h0,      12, 64'h8000_0000_0000_0000, 0, 1, 1, 32'h100, 8'hF0, 64'h0, 64'hFFFF_FFFF_8000_0000, 1, 0));
        tbl.push_back(tv(0, 0, 1, 1, 32'h002, 64'h0,       1, 64'hF00D_1234,         0, 0, 0, 32'h000, 8'h0C, 64'h0, 64'hF00D, 1, 0));
        foreach (tbl[i]) run(tbl[i]);

        // Reset while in WAIT: idle at once, the late response must be ignored.
        txn++;
        sel = 1'b0;
        v = tbl[3].v;
        issue(v);
        @(negedge clk); req_valid = 1'b0; gnt = 1'b1;
        @(negedge clk); gnt = 1'b0;
        chk("pre_rst_wait", ob.stall, 1);
        rst = 1'b0; #1;
        chk("rstw_ready", ob.req_ready, 1);
        chk("rstw_stall", ob.stall, 0);
        @(negedge clk); rst = 1'b1; rvalid = 1'b1; rdata = 64'h1111_2222;
        @(negedge clk); rvalid = 1'b0; rdata = '0;
        chk("rstw_nowb", ob.wb_valid, 0);
        chk("rstw_noexc", ob.exc, 0);
        @(negedge clk);
        chk("rstw_nowb2", ob.wb_valid, 0);
        chk("rstw_idle", ob.req_ready, 1);

        // Reset while in REQ: mem_req must drop without waiting for a clock edge.
        txn++;
        sel = 1'b1;
        v = tbl[6].v;
        issue(v);
        @(negedge clk); req_valid = 1'b0;
        chk("rstr_req_on", ob.mem_req, 1);
        rst = 1'b0; #1;
        chk("rstr_req_async", ob.mem_req, 0);
        chk("rstr_ready", ob.req_ready, 1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        // Request held during RESP: stall while busy, no second accept until IDLE.
        txn++;
        sel = 1'b0;
        v = tbl[2].v;
        issue(v);
        @(negedge clk);
        chk("hold_wbv", ob.wb_valid, 1);
        chk("hold_stall", ob.stall, 1);
        chk("hold_notready", ob.req_ready, 0);
        req_valid = 1'b0; #1;
        chk("hold_stall_drop", ob.stall, 0);
        @(negedge clk);
        chk("hold_idle", ob.req_ready, 1);
        chk("hold_pulse", ob.wb_valid, 0);

        for (int n = 0; n < 60; n++) begin
            v.sel   = 1'($urandom_range(0, 1));
            v.we    = 1'($urandom_range(0, 1));
            v.size  = 2'($urandom_range(0, 3));
            v.uns   = 1'($urandom_range(0, 1));
            v.addr  = 32'($urandom_range(0, 16'hFFFF));
            if ($urandom_range(0, 1) == 1) v.addr = v.addr & ~((32'd1 << v.size) - 32'd1);
            v.wdata = {$urandom, $urandom};
            v.rd    = 5'($urandom_range(0, 31));
            v.rdata = {$urandom, $urandom};
            v.err   = ($urandom_range(0, 7) == 0);
            v.gd    = $urandom_range(0, 5);
            v.rdly  = $urandom_range(0, 6);
            t.v = v;
            t.e = model(v);
            run(t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
